// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the register file's single write port between two writeback
//   requesters: A (ALU results) and B (load/memory results). Each requester
//   uses a valid/ready handshake. At most one grant is made per cycle. The
//   granted write reaches the register file from an output register one
//   cycle after the handshake. Writes to index 0 are accepted and consume a
//   slot, but reg_write stays low for them.
//
//   Build option: define REGFILE_ARB_RR_EN for round-robin arbitration on
//   contention. When it is undefined, A has fixed priority and last_grant is
//   kept only so the last winner can be observed.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              reg_write,
    output logic [31:0]       reg_dest,
    output logic [DATA_W-1:0] data_write,
    output logic              last_grant
);

    // The register index sits at bits [15:11] of the destination word.
    localparam int DEST_LSB = 11;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // The round-robin pointer is the only FSM state.
    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } gnt_e;

    gnt_e    lg_q;
    wr_req_t req_a, req_b, req_sel;
    logic    a_wins;
    logic    grant_b;
    logic    xfer;

    assign req_a = '{valid: a_valid, addr: a_addr, data: a_data};
    assign req_b = '{valid: b_valid, addr: b_addr, data: b_data};

`ifdef REGFILE_ARB_RR_EN
    // When both requesters are valid, A wins only if B was granted last.
    assign a_wins = (lg_q == GNT_B);
`else
    // Fixed priority. A always wins on contention.
    assign a_wins = 1'b1;
`endif

    // Handshake: no grant while reset is held, so no transfer completes
    // in a reset cycle.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!reset) begin
            a_ready = req_a.valid && (!req_b.valid || a_wins);
            b_ready = req_b.valid && !(req_a.valid && a_wins);
        end
    end

    assign grant_b = b_ready;
    assign xfer    = a_ready || b_ready;
    assign req_sel = grant_b ? req_b : req_a;

    // Pointer and write-port registers. reg_dest and data_write hold their
    // values between transfers. reg_write is a one-cycle pulse per write
    // to a nonzero index.
    always_ff @(posedge clk) begin
        if (reset) begin
            lg_q       <= GNT_B;
            reg_write  <= 1'b0;
            reg_dest   <= '0;
            data_write <= '0;
        end else if (xfer) begin
            lg_q       <= grant_b ? GNT_B : GNT_A;
            reg_write  <= (req_sel.addr != '0);
            reg_dest   <= 32'(req_sel.addr) << DEST_LSB;
            data_write <= req_sel.data;
        end else begin
            reg_write  <= 1'b0;
        end
    end

    assign last_grant = lg_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter. Inputs change 1 time unit after
// a rising edge. The combinational ready signals are checked after settling.
// Registered outputs are checked 1 time unit after the following edge.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready;
    logic        reg_write;
    logic [31:0] reg_dest;
    logic [31:0] data_write;
    logic        last_grant;

    int n_chk  = 0;
    int n_pass = 0;

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .reg_write  (reg_write),
        .reg_dest   (reg_dest),
        .data_write (data_write),
        .last_grant (last_grant)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h1111_1111;
        #1;
        n_chk++;
        if ({a_ready, b_ready} !== 2'b00)
            $display("FAIL reset_ready: got %b, expected 00", {a_ready, b_ready});
        else n_pass++;
        tick; tick;
        n_chk++;
        if ({reg_write, reg_dest, data_write, last_grant} !== {1'b0, 32'h0, 32'h0, 1'b1})
            $display("FAIL reset_outputs: got w=%b d=%h dw=%h lg=%b, expected 0/0/0/1",
                     reg_write, reg_dest, data_write, last_grant);
        else n_pass++;
        a_valid = 1'b0;
    endtask

    task automatic test_single_a;
        reset = 1'b0; a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h1111_1111;
        #1;
        n_chk++;
        if ({a_ready, b_ready} !== 2'b10)
            $display("FAIL single_a_ready: got %b, expected 10", {a_ready, b_ready});
        else n_pass++;
        tick;
        a_valid = 1'b0;
        n_chk++;
        if ({reg_write, reg_dest, data_write, last_grant} !== {1'b1, 32'h0000_1800, 32'h1111_1111, 1'b0})
            $display("FAIL single_a_out: got w=%b d=%h dw=%h lg=%b, expected 1/00001800/11111111/0",
                     reg_write, reg_dest, data_write, last_grant);
        else n_pass++;
        tick;
        n_chk++;
        if ({reg_write, reg_dest} !== {1'b0, 32'h0000_1800})
            $display("FAIL single_a_after: got w=%b d=%h, expected 0/00001800", reg_write, reg_dest);
        else n_pass++;
    endtask

    task automatic test_idle_hold;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h0000_0077;
        #1;
        n_chk++;
        if ({a_ready, b_ready} !== 2'b01)
            $display("FAIL idle_b_ready: got %b, expected 01", {a_ready, b_ready});
        else n_pass++;
        tick;
        b_valid = 1'b0;
        n_chk++;
        if ({reg_write, reg_dest, data_write, last_grant} !== {1'b1, 32'h0000_3800, 32'h0000_0077, 1'b1})
            $display("FAIL idle_write: got w=%b d=%h dw=%h lg=%b, expected 1/00003800/00000077/1",
                     reg_write, reg_dest, data_write, last_grant);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_chk++;
            if ({reg_write, reg_dest, data_write} !== {1'b0, 32'h0000_3800, 32'h0000_0077})
                $display("FAIL idle_hold[%0d]: got w=%b d=%h dw=%h, expected 0/00003800/00000077",
                         i, reg_write, reg_dest, data_write);
            else n_pass++;
        end
    endtask

    task automatic test_index0;
        // A to index 0 moves the pointer to A while leaving reg_write low.
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h0000_0005;
        #1;
        n_chk++;
        if (a_ready !== 1'b1)
            $display("FAIL idx0_a_ready: got %b, expected 1", a_ready);
        else n_pass++;
        tick;
        a_valid = 1'b0;
        n_chk++;
        if ({reg_write, reg_dest, data_write, last_grant} !== {1'b0, 32'h0, 32'h0000_0005, 1'b0})
            $display("FAIL idx0_a_out: got w=%b d=%h dw=%h lg=%b, expected 0/00000000/00000005/0",
                     reg_write, reg_dest, data_write, last_grant);
        else n_pass++;
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hDEAD_BEEF;
        #1;
        n_chk++;
        if (b_ready !== 1'b1)
            $display("FAIL idx0_b_ready: got %b, expected 1", b_ready);
        else n_pass++;
        tick;
        b_valid = 1'b0;
        n_chk++;
        if ({reg_write, reg_dest, data_write, last_grant} !== {1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1})
            $display("FAIL idx0_b_out: got w=%b d=%h dw=%h lg=%b, expected 0/00000000/deadbeef/1",
                     reg_write, reg_dest, data_write, last_grant);
        else n_pass++;
    endtask

    task automatic test_both_from_reset;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'hA;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'hB;
        #1;
        n_chk++;
        if ({a_ready, b_ready} !== 2'b10)
            $display("FAIL both_c0_ready: got %b, expected 10", {a_ready, b_ready});
        else n_pass++;
        tick;
        a_valid = 1'b0;
        #1;
        n_chk++;
        if ({reg_write, reg_dest, data_write, last_grant, a_ready, b_ready} !==
            {1'b1, 32'h0000_0800, 32'hA, 1'b0, 1'b0, 1'b1})
            $display("FAIL both_c1: got w=%b d=%h dw=%h lg=%b rdy=%b%b, expected 1/00000800/0000000a/0/01",
                     reg_write, reg_dest, data_write, last_grant, a_ready, b_ready);
        else n_pass++;
        tick;
        b_valid = 1'b0;
        n_chk++;
        if ({reg_write, reg_dest, data_write, last_grant} !== {1'b1, 32'h0000_1000, 32'hB, 1'b1})
            $display("FAIL both_c2: got w=%b d=%h dw=%h lg=%b, expected 1/00001000/0000000b/1",
                     reg_write, reg_dest, data_write, last_grant);
        else n_pass++;
        tick;
        n_chk++;
        if (reg_write !== 1'b0)
            $display("FAIL both_c3: got w=%b, expected 0", reg_write);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic exp_b;
        // Pointer is at B here, so A wins the first contested cycle.
        a_valid = 1'b1; a_addr = 5'd4; a_data = 32'hA0;
        b_valid = 1'b1; b_addr = 5'd5; b_data = 32'hB0;
        for (int i = 0; i < 6; i++) begin
`ifdef REGFILE_ARB_RR_EN
            exp_b = (i % 2) == 1;
`else
            exp_b = 1'b0;
`endif
            #1;
            n_chk++;
            if ({a_ready, b_ready} !== {~exp_b, exp_b})
                $display("FAIL b2b_ready[%0d]: got %b%b, expected %b%b", i, a_ready, b_ready, ~exp_b, exp_b);
            else n_pass++;
            tick;
            n_chk++;
            if ({reg_write, reg_dest, data_write, last_grant} !==
                {1'b1, (exp_b ? 32'h0000_2800 : 32'h0000_2000), (exp_b ? 32'hB0 : 32'hA0), exp_b})
                $display("FAIL b2b_out[%0d]: got w=%b d=%h dw=%h lg=%b, expected grant %s",
                         i, reg_write, reg_dest, data_write, last_grant, exp_b ? "B" : "A");
            else n_pass++;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h66;
        tick;
        reset = 1'b1;
        #1;
        n_chk++;
        if ({a_ready, reg_write, reg_dest, data_write} !== {1'b0, 1'b1, 32'h0000_3000, 32'h66})
            $display("FAIL rst_mid_c0: got rdy=%b w=%b d=%h dw=%h, expected 0/1/00003000/00000066",
                     a_ready, reg_write, reg_dest, data_write);
        else n_pass++;
        tick;
        n_chk++;
        if ({reg_write, reg_dest, data_write, last_grant} !== {1'b0, 32'h0, 32'h0, 1'b1})
            $display("FAIL rst_mid_c1: got w=%b d=%h dw=%h lg=%b, expected 0/0/0/1",
                     reg_write, reg_dest, data_write, last_grant);
        else n_pass++;
        reset = 1'b0; a_valid = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_single_a;
        test_idle_hold;
        test_index0;
        test_both_from_reset;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Arbitrates the register file's single write port between two writeback requesters: port A (ALU result path) and port B (load/memory result path). Each requester uses a valid/ready handshake. Each cycle the block grants at most one requester and drives the register file write controls from an output register. Writes to register 0 are accepted from the requester but never issued to the register file.

## Interface
Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, register index width; the index is placed in bits [15:11] of reg_dest.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- a_valid  input  1  requester A holds a write.
- a_addr  input  ADDR_W  destination index for A.
- a_data  input  DATA_W  write data for A.
- a_ready  output  1  A's write accepted this cycle (combinational).
- b_valid, b_addr, b_data, b_ready: same as the A ports, for requester B.
- reg_write  output  1  drives the register file write enable.
- reg_dest  output  32  destination word: bits [15:11] = index, all other bits 0.
- data_write  output  DATA_W  drives the register file write data.
- last_grant  output  1  0 = A, 1 = B; the requester granted most recently.

## Operation
- Handshake: a transfer on port X occurs in a cycle where X_valid=1 and X_ready=1. X_ready is never 1 while X_valid=0.
- X_ready depends combinationally on both valid inputs and on the priority state. There is no combinational path from valid or data inputs to reg_write, reg_dest or data_write.
- Requesters hold valid, addr and data stable until ready is asserted.
- Grant rule:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the requester other than last_grant (round-robin).
  - Neither valid: no grant.
- last_grant updates to the granted requester on every transfer, including transfers to index 0.
- Output register, on every clock edge after a transfer:
  - reg_dest = {16'b0, addr, 11'b0}.
  - data_write = the granted requester's data.
  - reg_write = 1 if addr != 0, otherwise 0.
- With no transfer: reg_write = 0; reg_dest and data_write hold their previous values.
- Throughput: one write per cycle sustained. With both requesters continuously valid, grants alternate A, B, A, B…
- States: the round-robin pointer (last_grant) is the only FSM state. IDLE and ACTIVE are implied by reg_write.

## Timing
- Reset values: reg_write=0, reg_dest=0, data_write=0, last_grant=1 (so A wins the first simultaneous contest). a_ready=0 and b_ready=0 while reset=1.
- Reset asserted mid-transfer: no handshake completes in that cycle. The write already registered from the previous cycle is cleared; reg_write=0 at the following edge.
- Latency: a handshake in cycle N produces reg_write/reg_dest/data_write valid during cycle N+1. The register file commits the write at the end of cycle N+1.
- Simultaneous requests to the same index: both are serviced in grant order. The later-granted value is the final register content.
- An index-0 write consumes a grant slot and a cycle and moves the round-robin pointer.

## Configuration
- Macro REGFILE_ARB_RR_EN.
- Defined: round-robin arbitration, as described above.
- Undefined: fixed priority.
  - A always wins when both requesters are valid.
  - last_grant still updates, for observability only.
  - B can starve under continuous A traffic; this is accepted behaviour in that configuration.

## Test plan
- Reset, then a_valid=1, a_addr=3, a_data=0x11111111 for one cycle -> a_ready=1 that cycle. Next cycle: reg_write=1, reg_dest=0x00001800, data_write=0x11111111, last_grant=0.
- Both valid from the first cycle after reset (A: addr 1, 0xA; B: addr 2, 0xB), held until accepted -> A granted in cycle 0 and B in cycle 1. reg_write is high for 2 consecutive cycles, with reg_dest 0x00000800 then 0x00001000.
- Both valid continuously for 6 cycles with REGFILE_ARB_RR_EN defined -> grant sequence A, B, A, B, A, B. Without the macro -> all 6 grants to A and b_ready=0 throughout.
- b_valid=1, b_addr=0, b_data=0xDEADBEEF -> b_ready=1. Next cycle: reg_write=0 and last_grant=1.
- reset asserted in the same cycle as a_valid=1 -> a_ready=0. Next cycle: all outputs at their reset values and last_grant=1.
- Idle 3 cycles after a write to addr 7 -> reg_write=0 throughout; reg_dest holds 0x00003800.
